// File: rtl/pat_det_pkg.sv
// pat_det_pkg: shared FSM encoding and default widths for pattern_detector_p
package pat_det_pkg;
    localparam int PAT_W_DEF = 4;
    localparam int CNT_W_DEF = 8;
    typedef enum logic {FILL = 1'b0, ARMED = 1'b1} pd_state_t;
endpackage

// File: rtl/pd_shift_reg.sv
// pd_shift_reg: serial-in window register, MSB-first shift with sync clear
module pd_shift_reg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    input  logic         si,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= '0;
        else if (clear) q <= '0;
        else if (en) q <= {q[W-2:0], si};
    end
endmodule

// File: rtl/pattern_detector_p.sv
// pattern_detector_p: masked serial pattern detector; PAT_DET_MATCH_COUNT_EN adds match_cnt
module pattern_detector_p
    import pat_det_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din_valid,
    input  logic             din,
    input  logic [PAT_W-1:0] pattern,
    input  logic [PAT_W-1:0] mask,
    input  logic             overlap_en,
    input  logic             clear,
    output logic             match,
    output logic             armed
`ifdef PAT_DET_MATCH_COUNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);
    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);

    logic [PAT_W-1:0] sr, sr_next;
    logic [FW-1:0]    fill, fill_inc, fill_next;
    pd_state_t        state, state_next;
    logic             hit;

    pd_shift_reg #(.W(PAT_W)) u_sr (
        .clk  (clk),
        .reset(reset),
        .clear(clear),
        .en   (din_valid),
        .si   (din),
        .q    (sr)
    );

    always_comb begin
        sr_next    = {sr[PAT_W-2:0], din};
        fill_inc   = (fill == FULL) ? FULL : fill + 1'b1;
        hit        = din_valid && !clear && (fill_inc == FULL) && (((sr_next ^ pattern) & mask) == '0);
        // without overlap a hit consumes the whole window
        fill_next  = clear ? '0 : !din_valid ? fill : (hit && !overlap_en) ? '0 : fill_inc;
        state_next = (fill_next == FULL) ? ARMED : FILL;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FILL;
        else state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill  <= '0;
            match <= 1'b0;
        end else begin
            fill  <= fill_next;
            match <= hit;
        end
    end

    assign armed = (state == ARMED);

`ifdef PAT_DET_MATCH_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) match_cnt <= '0;
        else if (clear) match_cnt <= '0;
        else if (match && (match_cnt != '1)) match_cnt <= match_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_pattern_detector_p.sv
// tb_pattern_detector_p: directed self-checking bench for pattern_detector_p
module tb_pattern_detector_p;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       din_valid = 1'b0;
    logic       din = 1'b0;
    logic [3:0] pattern = 4'b0110;
    logic [3:0] mask = 4'b1111;
    logic       overlap_en = 1'b1;
    logic       clear = 1'b0;
    logic       match, armed;
    int         n_checks = 0;
    int         n_fail = 0;
`ifdef PAT_DET_MATCH_COUNT_EN
    logic [1:0] match_cnt;
`endif

    pattern_detector_p #(.PAT_W(4), .CNT_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .din_valid (din_valid),
        .din       (din),
        .pattern   (pattern),
        .mask      (mask),
        .overlap_en(overlap_en),
        .clear     (clear),
        .match     (match),
        .armed     (armed)
`ifdef PAT_DET_MATCH_COUNT_EN
        ,
        .match_cnt (match_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic d, input logic c);
        din_valid = v;
        din       = d;
        clear     = c;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic feed(input string tag, input logic d, input logic em, input logic ea);
        step(1'b1, d, 1'b0);
        check({tag, " match"}, 32'(match), 32'(em));
        check({tag, " armed"}, 32'(armed), 32'(ea));
    endtask

    task automatic flush();
        step(1'b0, 1'b0, 1'b1);
        check("flush match", 32'(match), 32'd0);
        check("flush armed", 32'(armed), 32'd0);
    endtask

    logic [6:0] s7;
    logic [3:0] s4;

    initial begin
        s7 = 7'b0110110;
        s4 = 4'b0110;
        #2;
        check("reset match", 32'(match), 32'd0);
        check("reset armed", 32'(armed), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        overlap_en = 1'b1;
        for (int i = 0; i < 7; i++)
            feed($sformatf("ovl b%0d", i + 1), s7[6-i], (i == 3) || (i == 6), i >= 3);
        flush();

        overlap_en = 1'b0;
        for (int i = 0; i < 7; i++)
            feed($sformatf("novl b%0d", i + 1), s7[6-i], i == 3, 1'b0);
        flush();

        mask = 4'b1001;
        for (int i = 0; i < 4; i++)
            feed($sformatf("mask b%0d", i + 1), 1'b0, i == 3, 1'b0);
        mask = 4'b1111;
        flush();

        for (int i = 0; i < 4; i++) begin
            feed($sformatf("gap b%0d", i + 1), s4[3-i], i == 3, 1'b0);
            for (int k = 0; k < 3; k++) begin
                step(1'b0, 1'b1, 1'b0);
                check($sformatf("gap idle %0d.%0d", i + 1, k), 32'(match), 32'd0);
            end
        end
        flush();

        feed("clr b1", 1'b0, 1'b0, 1'b0);
        feed("clr b2", 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check("clr b3 match", 32'(match), 32'd0);
        check("clr b3 armed", 32'(armed), 32'd0);
        for (int i = 0; i < 4; i++)
            feed($sformatf("clr2 b%0d", i + 1), s4[3-i], i == 3, 1'b0);
        flush();

        overlap_en = 1'b1;
        mask = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            feed($sformatf("m0 b%0d", i + 1), i[0], i >= 3, i >= 3);
`ifdef PAT_DET_MATCH_COUNT_EN
            check($sformatf("cnt b%0d", i + 1), 32'(match_cnt), (i < 4) ? 32'd0 : (i == 4) ? 32'd1 : (i == 5) ? 32'd2 : 32'd3);
`endif
        end
        step(1'b0, 1'b0, 1'b0);
        check("m0 idle match", 32'(match), 32'd0);
        check("m0 idle armed", 32'(armed), 32'd1);
`ifdef PAT_DET_MATCH_COUNT_EN
        check("cnt saturated", 32'(match_cnt), 32'd3);
`endif
        feed("m0 b9", 1'b1, 1'b1, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("async match", 32'(match), 32'd0);
        check("async armed", 32'(armed), 32'd0);
`ifdef PAT_DET_MATCH_COUNT_EN
        check("async cnt", 32'(match_cnt), 32'd0);
`endif
        @(posedge clk);
        #1 reset = 1'b0;
        mask = 4'b1111;
        for (int i = 0; i < 4; i++)
            feed($sformatf("post b%0d", i + 1), s4[3-i], i == 3, i == 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
